// File: rtl/lift_pkg.sv
// Shared types and default sizing for the lift control core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lift_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } lift_state_t;

  localparam int LIFT_NUM_FLOORS  = 4;
  localparam int LIFT_MOVE_CYCLES = 8;
  localparam int LIFT_DOOR_CYCLES = 4;

endpackage

// File: rtl/lift_dir_sel.sv
// Direction selection: classifies pending requests relative to a floor and
// picks a SCAN direction (keep dir_up's side when it has work, else turn).
// Latency: combinational. Backpressure: none.
// Ports: pending (latched requests), floor (reference floor), dir_up (last
// direction); req_here/req_above/req_below (request at/above/below floor),
// go_up/go_down (chosen direction, never both).
module lift_dir_sel
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = LIFT_NUM_FLOORS,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  dir_up,
  output logic                  req_here,
  output logic                  req_above,
  output logic                  req_below,
  output logic                  go_up,
  output logic                  go_down
);

  always_comb begin
    req_here  = 1'b0;
    req_above = 1'b0;
    req_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (i == int'(floor))     req_here  = 1'b1;
        else if (i > int'(floor)) req_above = 1'b1;
        else                      req_below = 1'b1;
      end
    end
  end

  // The remembered direction wins when both sides have work.
  assign go_up   = req_above & (dir_up | ~req_below);
  assign go_down = req_below & (~dir_up | ~req_above);

endmodule

// File: rtl/lift_fsm.sv
// Lift control core: latches per-floor request pulses, schedules the car with
// SCAN, times floor travel and door dwell, drives car/door status.
// Latency: pulse -> pending 1 cycle; pending -> IDLE decision 1 cycle.
// Backpressure: none; requests are sticky in pending until served.
// Ports: clk, rst_n (sync, active-low); req_pulse (one-cycle per-floor
// requests); current_floor; moving_up/moving_down/door_open (one-hot or
// zero); pending (unserved requests); busy (not idle or work pending).
module lift_fsm
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS  = LIFT_NUM_FLOORS,
  parameter int FLOOR_W     = $clog2(NUM_FLOORS),
  parameter int MOVE_CYCLES = LIFT_MOVE_CYCLES,
  parameter int DOOR_CYCLES = LIFT_DOOR_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req_pulse,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);

  lift_state_t           state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [FLOOR_W-1:0]    floor_nxt, nf;
  logic                  dir_up, dir_nxt;
  logic [NUM_FLOORS-1:0] pending_nxt, clear_mask, latch_mask;
  logic [NUM_FLOORS-1:0] cur_bit, nf_bit;

  logic cur_here, cur_above, cur_below, cur_go_up, cur_go_down;
  logic nf_here, nf_above, nf_below, nf_go_up, nf_go_down;
  logic dir_sel_unused;

  // Floor the car reaches at the end of the current move.
  assign nf      = (state == MOVE_DOWN) ? current_floor - FLOOR_W'(1)
                                        : current_floor + FLOOR_W'(1);
  assign cur_bit = NUM_FLOORS'(1) << current_floor;
  assign nf_bit  = NUM_FLOORS'(1) << nf;

  lift_dir_sel #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_cur_sel (
    .pending   (pending),
    .floor     (current_floor),
    .dir_up    (dir_up),
    .req_here  (cur_here),
    .req_above (cur_above),
    .req_below (cur_below),
    .go_up     (cur_go_up),
    .go_down   (cur_go_down)
  );

  lift_dir_sel #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_nf_sel (
    .pending   (pending),
    .floor     (nf),
    .dir_up    (dir_up),
    .req_here  (nf_here),
    .req_above (nf_above),
    .req_below (nf_below),
    .go_up     (nf_go_up),
    .go_down   (nf_go_down)
  );

  // Outputs of the shared selector that this core does not consume.
  assign dir_sel_unused = &{cur_above, cur_below, nf_go_up, nf_go_down};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      current_floor <= '0;
      dir_up        <= 1'b1;
      pending       <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      current_floor <= floor_nxt;
      dir_up        <= dir_nxt;
      pending       <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    floor_nxt  = current_floor;
    dir_nxt    = dir_up;
    clear_mask = '0;
    latch_mask = req_pulse;

    case (state)
      IDLE: begin
        if (cur_here) begin
          state_nxt  = DOOR_OPEN;
          cnt_nxt    = '0;
          clear_mask = cur_bit;
        end else if (cur_go_up) begin
          state_nxt = MOVE_UP;
          dir_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else if (cur_go_down) begin
          state_nxt = MOVE_DOWN;
          dir_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (cnt == MOVE_LAST) begin
          cnt_nxt   = '0;
          floor_nxt = nf;
          // Decide on the arrival floor so the door opens with no idle gap.
          if (nf_here) begin
            state_nxt  = DOOR_OPEN;
            clear_mask = nf_bit;
          end else if ((state == MOVE_UP) ? nf_above : nf_below) begin
            state_nxt = state;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DOOR_OPEN: begin
        // A press for this floor holds the door instead of queuing a request.
        latch_mask = req_pulse & ~cur_bit;
        if (|(req_pulse & cur_bit)) begin
          cnt_nxt = '0;
        end else if (cnt == DOOR_LAST) begin
          cnt_nxt = '0;
          if (cur_go_up) begin
            state_nxt = MOVE_UP;
            dir_nxt   = 1'b1;
          end else if (cur_go_down) begin
            state_nxt = MOVE_DOWN;
            dir_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Clear beats a same-edge request: that floor is being served now.
    pending_nxt = (pending | latch_mask) & ~clear_mask;
  end

  assign moving_up   = (state == MOVE_UP);
  assign moving_down = (state == MOVE_DOWN);
  assign door_open   = (state == DOOR_OPEN);
  assign busy        = (state != IDLE) || (|pending);

endmodule
